warden_sequencer: RTL and testbench

Upstream controller for one prisoners_module instance. It holds the box contents and runs the loop-following strategy for each prisoner 0..N_BOXES-1. For every box opened it drives the prisoner's state_reg, guard_key and input_data through a Reset→Load→Compare sequence, then consumes the prisoner's fail/attempted outputs. It reports per-prisoner results and an overall success flag.

---
 rtl/warden_sequencer.sv | 164 ++++++++++++++++
 tb/tb_warden_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/warden_sequencer.sv
// rtl/warden_sequencer.sv - drives one prisoner through the loop-following strategy
// Opens cost four cycles (Reset, Load, Compare, Check); results accumulate per prisoner.
module warden_sequencer #(
  parameter int          N_BOXES   = 8,
  parameter int          MAX_OPENS = 4,
  parameter logic [31:0] GUARD_KEY = 32'hCAFEFACE,
  localparam int         AW        = $clog2(N_BOXES),
  localparam int         CW        = $clog2(N_BOXES + 1),
  localparam int         OW        = $clog2(MAX_OPENS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               box_wr_en,
  input  logic [AW-1:0]      box_wr_addr,
  input  logic [7:0]         box_wr_data,
  output logic [2:0]         state_reg,
  output logic [31:0]        guard_key,
  output logic [7:0]         input_data,
  input  logic               fail,
  input  logic               attempted,
  output logic               busy,
  output logic               done,
  output logic               success,
  output logic [CW-1:0]      fail_count,
  output logic [N_BOXES-1:0] result_vec,
  output logic               err
);

  typedef enum logic [2:0] {S_IDLE, S_P_RST, S_P_LOAD, S_P_CMP, S_P_CHK, S_DONE} state_t;

  localparam logic [2:0] CMD_RESET   = 3'b100;
  localparam logic [2:0] CMD_LOAD    = 3'b001;
  localparam logic [2:0] CMD_COMPARE = 3'b010;
  localparam logic [2:0] CMD_HOLD    = 3'b000;

  state_t               r_state;
  logic [7:0]           r_box [N_BOXES];
  logic [AW-1:0]        r_p;
  logic [AW-1:0]        r_b;
  logic [OW-1:0]        r_opens;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_success;
  logic [CW-1:0]        r_fail_count;
  logic [N_BOXES-1:0]   r_result_vec;
  logic                 r_err;
  logic [2:0]           r_state_reg;
  logic [31:0]          r_guard_key;
  logic [7:0]           r_input_data;

  logic [7:0]           w_box_val;
  logic                 w_failed;
  logic                 w_last_open;
  logic                 w_bad_box;
  logic                 w_advance;
  logic                 w_fc_inc;
  logic [CW-1:0]        w_fc_next;
  logic                 w_last_p;

  assign w_box_val   = r_box[r_b];
  // A Compare the prisoner did not register is scored as a failed open.
  assign w_failed    = fail || !attempted;
  assign w_last_open = (int'(r_opens) + 1) == MAX_OPENS;
  assign w_bad_box   = int'(w_box_val) >= N_BOXES;
  assign w_advance   = !w_failed || w_last_open || w_bad_box;
  assign w_fc_inc    = w_failed && (w_last_open || w_bad_box);
  assign w_fc_next   = r_fail_count + CW'(w_fc_inc);
  assign w_last_p    = r_p == AW'(N_BOXES - 1);

  // Box contents survive reset; only a write while idle changes them.
  always_ff @(posedge clk) begin
    if (box_wr_en && !r_busy) r_box[box_wr_addr] <= box_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_p          <= '0;
      r_b          <= '0;
      r_opens      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_success    <= 1'b0;
      r_fail_count <= '0;
      r_result_vec <= '0;
      r_err        <= 1'b0;
      r_state_reg  <= CMD_RESET;
      r_guard_key  <= '0;
      r_input_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state_reg <= CMD_RESET;
          if (start) begin
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_fail_count <= '0;
            r_result_vec <= '0;
            r_err        <= 1'b0;
            r_p          <= '0;
            r_b          <= '0;
            r_opens      <= '0;
            r_state      <= S_P_RST;
          end
        end
        S_P_RST: begin
          r_state      <= S_P_LOAD;
          r_state_reg  <= CMD_LOAD;
          r_guard_key  <= GUARD_KEY;
          r_input_data <= 8'(r_p);
        end
        S_P_LOAD: begin
          r_state      <= S_P_CMP;
          r_state_reg  <= CMD_COMPARE;
          r_guard_key  <= '0;
          r_input_data <= w_box_val;
        end
        S_P_CMP: begin
          r_state      <= S_P_CHK;
          r_state_reg  <= CMD_HOLD;
          r_input_data <= '0;
        end
        S_P_CHK: begin
          r_state_reg  <= CMD_RESET;
          r_fail_count <= w_fc_next;
          if (!attempted) r_err <= 1'b1;
          if (!w_failed) r_result_vec[r_p] <= 1'b1;
          if (w_failed && !w_last_open && w_bad_box) r_err <= 1'b1;
          if (w_advance) begin
            r_opens <= '0;
            if (w_last_p) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_success <= (w_fc_next == '0);
            end else begin
              r_p     <= r_p + 1'b1;
              r_b     <= r_p + 1'b1;
              r_state <= S_P_RST;
            end
          end else begin
            r_opens <= r_opens + 1'b1;
            r_b     <= w_box_val[AW-1:0];
            r_state <= S_P_RST;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign success    = r_success;
  assign fail_count = r_fail_count;
  assign result_vec = r_result_vec;
  assign err        = r_err;
  assign state_reg  = r_state_reg;
  assign guard_key  = r_guard_key;
  assign input_data = r_input_data;

endmodule

// File: tb/tb_warden_sequencer.sv
// tb/tb_warden_sequencer.sv - scoreboard bench for warden_sequencer with a behavioural prisoner
module tb_warden_sequencer;

  localparam int          N     = 8;
  localparam int          MAXO  = 4;
  localparam logic [31:0] GK    = 32'hCAFEFACE;
  localparam int          LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       box_wr_en = 1'b0;
  logic [2:0] box_wr_addr = '0;
  logic [7:0] box_wr_data = '0;
  logic [2:0] state_reg;
  logic [31:0] guard_key;
  logic [7:0] input_data;
  logic       fail, attempted;
  logic       busy, done, success;
  logic [3:0] fail_count;
  logic [7:0] result_vec;
  logic       err;

  typedef struct {
    int         cycles;
    logic       success;
    int         fc;
    logic [7:0] rv;
    logic       err;
  } exp_t;

  exp_t       q_res[$];
  logic [7:0] q_cmp[$];
  logic [7:0] m_box[N];
  logic [7:0] pnum;
  int         n_tests = 0;
  int         n_fail  = 0;

  warden_sequencer #(.N_BOXES(N), .MAX_OPENS(MAXO), .GUARD_KEY(GK)) dut (
    .clk(clk), .rst(rst), .start(start), .box_wr_en(box_wr_en),
    .box_wr_addr(box_wr_addr), .box_wr_data(box_wr_data),
    .state_reg(state_reg), .guard_key(guard_key), .input_data(input_data),
    .fail(fail), .attempted(attempted), .busy(busy), .done(done),
    .success(success), .fail_count(fail_count), .result_vec(result_vec), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Prisoner: Reset clears flags, Load latches number when key matches, Compare scores the box.
  always @(posedge clk) begin
    if (rst) begin
      fail <= 1'b0; attempted <= 1'b0; pnum <= '0;
    end else begin
      case (state_reg)
        3'b100: begin fail <= 1'b0; attempted <= 1'b0; end
        3'b001: if (guard_key == GK) pnum <= input_data;
        3'b010: begin attempted <= 1'b1; fail <= (input_data != pnum); end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && state_reg == 3'b001) check("load_key", guard_key, GK);
    if (!rst && state_reg == 3'b010) begin
      if (q_cmp.size() == 0) check("cmp_underflow", 1, 0);
      else check("cmp_content", input_data, q_cmp.pop_front());
    end
  end

  task automatic write_box(input int a, input logic [7:0] d);
    box_wr_en = 1'b1; box_wr_addr = 3'(a); box_wr_data = d;
    m_box[a] = d;
    tick();
    box_wr_en = 1'b0;
  endtask

  task automatic push_model();
    exp_t e;
    int   b, opens;
    logic [7:0] c;
    e.fc = 0; e.rv = '0; e.err = 1'b0; opens = 0;
    for (int p = 0; p < N; p++) begin
      b = p;
      for (int k = 0; k < MAXO; k++) begin
        c = m_box[b];
        q_cmp.push_back(c);
        opens++;
        if (int'(c) == p) begin e.rv[p] = 1'b1; break; end
        if (k + 1 == MAXO) begin e.fc++; break; end
        if (int'(c) >= N) begin e.err = 1'b1; e.fc++; break; end
        b = int'(c);
      end
    end
    e.cycles  = 4 * opens;
    e.success = (e.fc == 0);
    q_res.push_back(e);
  endtask

  // wr_last: rewrite the last box on the start edge; rst_at/dist_at <0 disable those events.
  task automatic run_case(input bit wr_last, input int rst_at, input int dist_at);
    exp_t e;
    int   n;
    push_model();
    start = 1'b1;
    if (wr_last) begin
      box_wr_en = 1'b1; box_wr_addr = 3'(N - 1); box_wr_data = m_box[N-1];
    end
    tick();
    start = 1'b0; box_wr_en = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < LIMIT) begin
      if (n == dist_at) begin
        start = 1'b1; box_wr_en = 1'b1; box_wr_addr = 3'd2; box_wr_data = 8'h55;
      end
      if (n == rst_at) rst = 1'b1;
      tick();
      n++;
      start = 1'b0; box_wr_en = 1'b0;
      if (rst) begin
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_state_reg", state_reg, 3'b100);
        check("rst_done", done, 0);
        check("rst_success", success, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_result_vec", result_vec, 0);
        check("rst_err", err, 0);
        check("rst_guard_key", guard_key, 0);
        check("rst_input_data", input_data, 0);
        q_cmp.delete();
        void'(q_res.pop_front());
        return;
      end
    end
    check("done_timeout", (n < LIMIT), 1);
    e = q_res.pop_front();
    check("run_cycles", n, e.cycles);
    check("success", success, e.success);
    check("fail_count", fail_count, e.fc);
    check("result_vec", result_vec, e.rv);
    check("err", err, e.err);
    check("busy_at_done", busy, 0);
    check("cmp_leftover", q_cmp.size(), 0);
  endtask

  initial begin
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state_reg", state_reg, 3'b100);
    check("reset_result_vec", result_vec, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    tick();

    // Identity: one open per prisoner; last write shares the start edge.
    for (int i = 0; i < N - 1; i++) write_box(i, 8'(i));
    m_box[N-1] = 8'(N - 1);
    run_case(1'b1, -1, -1);

    // Single 8-cycle: everyone exhausts MAX_OPENS.
    for (int i = 0; i < N; i++) write_box(i, 8'((i + 1) % N));
    run_case(1'b0, -1, -1);

    // Two 4-cycles: everyone succeeds on the fourth open.
    for (int i = 0; i < N; i++) write_box(i, 8'((i & 4) | ((i + 1) & 3)));
    run_case(1'b0, -1, -1);

    // Out-of-range content in box 0.
    for (int i = 0; i < N; i++) write_box(i, (i == 0) ? 8'd9 : 8'(i));
    run_case(1'b0, -1, -1);

    // Reset mid-run, then rerun on the untouched boxes.
    run_case(1'b0, 10, -1);
    run_case(1'b0, -1, -1);

    // Start and write mid-run are dropped; a rerun sees the same boxes.
    for (int i = 0; i < N; i++) write_box(i, 8'((i & 4) | ((i + 1) & 3)));
    run_case(1'b0, -1, 20);
    run_case(1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
